// File: rtl/controller_param.sv
// Tick sequencer for a crossbar neuron core: walks every neuron through
// load, per-axon accumulate, optional leak, threshold and write-back.
module controller_param #(
    parameter int NUM_NEURONS = 16,
    parameter int NUM_AXONS   = 16,
    parameter int TICK_W      = 8,
    localparam int NA_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int AX_W = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              leak_en,
    input  logic              reset_mode,
    input  logic              potential_ovf,
    input  logic              spike_on_axon,
    input  logic              crossbar,
    input  logic              in_ex,
    input  logic              leak_sign,
    output logic [1:0]        s_output_potential,
    output logic [1:0]        s_adder,
    output logic [NA_W-1:0]   neuron_addr,
    output logic [AX_W-1:0]   axon_addr,
    output logic              spike_buffer_wen,
    output logic              output_spike_buffer_wen,
    output logic              output_spike_buffer_dout,
    output logic              potential_memory_wen,
    output logic              ready,
    output logic              done,
    output logic [TICK_W-1:0] tick_count
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_START,
        S_LOAD,
        S_ACC,
        S_LEAK,
        S_THRESH,
        S_LOOP
    } state_t;

    localparam logic [NA_W-1:0] NEURON_LAST = NA_W'(NUM_NEURONS - 1);
    localparam logic [AX_W-1:0] AXON_LAST   = AX_W'(NUM_AXONS - 1);

    localparam logic [1:0] OP_HOLD  = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_ZERO  = 2'd2;
    localparam logic [1:0] OP_ADDER = 2'd3;

    localparam logic [1:0] ADD_WEIGHT = 2'd0;
    localparam logic [1:0] SUB_WEIGHT = 2'd1;
    localparam logic [1:0] ADD_LEAK   = 2'd2;
    localparam logic [1:0] ADD_THRESH = 2'd3;

    state_t              state_q, state_d;
    logic [NA_W-1:0]     neuron_q, neuron_d;
    logic [AX_W-1:0]     axon_q, axon_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                leak_en_q, leak_en_d;
    logic                reset_mode_q, reset_mode_d;
    logic                true_ovf;

    // The adder flag only means saturation when it disagrees with the operation direction.
    assign true_ovf = (in_ex & potential_ovf) | (~in_ex & ~potential_ovf);

    always_comb begin
        state_d      = state_q;
        neuron_d     = neuron_q;
        axon_d       = axon_q;
        tick_d       = tick_q;
        leak_en_d    = leak_en_q;
        reset_mode_d = reset_mode_q;
        case (state_q)
            S_WAIT: begin
                if (start) begin
                    state_d      = S_START;
                    leak_en_d    = leak_en;
                    reset_mode_d = reset_mode;
                end
            end
            S_START: begin
                neuron_d = '0;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                axon_d  = '0;
                state_d = S_ACC;
            end
            S_ACC: begin
                if (axon_q == AXON_LAST) begin
                    axon_d  = '0;
                    state_d = leak_en_q ? S_LEAK : S_THRESH;
                end else begin
                    axon_d = axon_q + AX_W'(1);
                end
            end
            S_LEAK: begin
                state_d = S_THRESH;
            end
            S_THRESH: begin
                state_d = S_LOOP;
            end
            S_LOOP: begin
                if (neuron_q == NEURON_LAST) begin
                    neuron_d = '0;
                    tick_d   = tick_q + TICK_W'(1);
                    state_d  = S_WAIT;
                end else begin
                    neuron_d = neuron_q + NA_W'(1);
                    state_d  = S_LOAD;
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT;
            neuron_q     <= '0;
            axon_q       <= '0;
            tick_q       <= '0;
            leak_en_q    <= 1'b0;
            reset_mode_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            neuron_q     <= neuron_d;
            axon_q       <= axon_d;
            tick_q       <= tick_d;
            leak_en_q    <= leak_en_d;
            reset_mode_q <= reset_mode_d;
        end
    end

    // Datapath controls depend on live flags, so they are decoded rather than registered.
    always_comb begin
        s_output_potential       = OP_HOLD;
        s_adder                  = ADD_WEIGHT;
        spike_buffer_wen         = 1'b0;
        output_spike_buffer_wen  = 1'b0;
        output_spike_buffer_dout = 1'b0;
        potential_memory_wen     = 1'b0;
        ready                    = 1'b0;
        done                     = 1'b0;
        case (state_q)
            S_WAIT: begin
                ready = 1'b1;
            end
            S_START: begin
                spike_buffer_wen = 1'b1;
            end
            S_LOAD: begin
                s_output_potential = OP_LOAD;
            end
            S_ACC: begin
                s_adder = in_ex ? ADD_WEIGHT : SUB_WEIGHT;
                if (spike_on_axon && crossbar && !true_ovf) begin
                    s_output_potential = OP_ADDER;
                end
            end
            S_LEAK: begin
                s_adder = ADD_LEAK;
                if (!(potential_ovf ^ leak_sign)) begin
                    s_output_potential = OP_ADDER;
                end
            end
            S_THRESH: begin
                s_adder                  = ADD_THRESH;
                output_spike_buffer_wen  = 1'b1;
                output_spike_buffer_dout = potential_ovf;
                if (potential_ovf) begin
                    s_output_potential = reset_mode_q ? OP_ZERO : OP_ADDER;
                end
            end
            S_LOOP: begin
                potential_memory_wen = 1'b1;
                done                 = (neuron_q == NEURON_LAST);
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign neuron_addr = neuron_q;
    assign axon_addr   = axon_q;
    assign tick_count  = tick_q;

endmodule

// File: tb/tb_controller_param.sv
// Directed bench for controller_param: a hand-computed 2x2 vector table plus
// multi-cycle sequences on 4x3 and default 16x16 instances.
module tb_controller_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s, rst_m, rst_d;
    logic start_s, start_m, start_d;
    logic leak_en, reset_mode, potential_ovf, spike_on_axon, crossbar, in_ex, leak_sign;

    logic [1:0] sop_s, sadd_s;
    logic [0:0] naddr_s, aaddr_s;
    logic       sbw_s, osbw_s, osbd_s, pmw_s, rdy_s, done_s;
    logic [1:0] tick_s;

    logic [1:0] sop_m, sadd_m;
    logic [1:0] naddr_m, aaddr_m;
    logic       sbw_m, osbw_m, osbd_m, pmw_m, rdy_m, done_m;
    logic [7:0] tick_m;

    logic [1:0] sop_d, sadd_d;
    logic [3:0] naddr_d, aaddr_d;
    logic       sbw_d, osbw_d, osbd_d, pmw_d, rdy_d, done_d;
    logic [7:0] tick_d;

    controller_param #(.NUM_NEURONS(2), .NUM_AXONS(2), .TICK_W(2)) dut_s (
        .clk(clk), .rst(rst_s), .start(start_s), .leak_en(leak_en), .reset_mode(reset_mode),
        .potential_ovf(potential_ovf), .spike_on_axon(spike_on_axon), .crossbar(crossbar),
        .in_ex(in_ex), .leak_sign(leak_sign), .s_output_potential(sop_s), .s_adder(sadd_s),
        .neuron_addr(naddr_s), .axon_addr(aaddr_s), .spike_buffer_wen(sbw_s),
        .output_spike_buffer_wen(osbw_s), .output_spike_buffer_dout(osbd_s),
        .potential_memory_wen(pmw_s), .ready(rdy_s), .done(done_s), .tick_count(tick_s)
    );

    controller_param #(.NUM_NEURONS(4), .NUM_AXONS(3)) dut_m (
        .clk(clk), .rst(rst_m), .start(start_m), .leak_en(leak_en), .reset_mode(reset_mode),
        .potential_ovf(potential_ovf), .spike_on_axon(spike_on_axon), .crossbar(crossbar),
        .in_ex(in_ex), .leak_sign(leak_sign), .s_output_potential(sop_m), .s_adder(sadd_m),
        .neuron_addr(naddr_m), .axon_addr(aaddr_m), .spike_buffer_wen(sbw_m),
        .output_spike_buffer_wen(osbw_m), .output_spike_buffer_dout(osbd_m),
        .potential_memory_wen(pmw_m), .ready(rdy_m), .done(done_m), .tick_count(tick_m)
    );

    controller_param dut_d (
        .clk(clk), .rst(rst_d), .start(start_d), .leak_en(leak_en), .reset_mode(reset_mode),
        .potential_ovf(potential_ovf), .spike_on_axon(spike_on_axon), .crossbar(crossbar),
        .in_ex(in_ex), .leak_sign(leak_sign), .s_output_potential(sop_d), .s_adder(sadd_d),
        .neuron_addr(naddr_d), .axon_addr(aaddr_d), .spike_buffer_wen(sbw_d),
        .output_spike_buffer_wen(osbw_d), .output_spike_buffer_dout(osbd_d),
        .potential_memory_wen(pmw_d), .ready(rdy_d), .done(done_d), .tick_count(tick_d)
    );

    // strb = {spike_buffer_wen, out_spike_wen, out_spike_dout, pot_mem_wen, ready, done}
    typedef struct {
        bit       st, le, rm, ovf, spk, xb, ie, ls;
        bit [1:0] sop, sadd;
        bit       na, aa;
        bit [5:0] strb;
        bit [1:0] tick;
    } vec_t;

    vec_t vecs[28];
    int   compared = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit ovf, input bit spk, input bit xb, input bit ie, input bit ls);
        potential_ovf = ovf;
        spike_on_axon = spk;
        crossbar      = xb;
        in_ex         = ie;
        leak_sign     = ls;
    endtask

    task automatic randomStimulus();
        applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        leak_en    = 1'($urandom);
        reset_mode = 1'($urandom);
    endtask

    int       cyc, sbw_cnt, leak_cnt, done_cnt;
    bit       got, rm_lat;
    bit       tovf;
    bit [1:0] exp_sop, exp_sadd;

    initial begin
        //           st le rm ovf spk xb ie ls  sop sadd na aa  strb        tick
        vecs[0]  = '{1, 1, 0, 0,  0,  0, 0, 0,  0,  0,   0, 0,  6'b000010, 0};
        vecs[1]  = '{0, 0, 0, 0,  0,  0, 0, 0,  0,  0,   0, 0,  6'b100000, 0};
        vecs[2]  = '{0, 0, 0, 0,  0,  0, 0, 0,  1,  0,   0, 0,  6'b000000, 0};
        vecs[3]  = '{0, 0, 0, 0,  1,  1, 1, 0,  3,  0,   0, 0,  6'b000000, 0};
        vecs[4]  = '{0, 0, 0, 1,  1,  1, 0, 0,  3,  1,   0, 1,  6'b000000, 0};
        vecs[5]  = '{0, 0, 0, 0,  0,  0, 0, 0,  3,  2,   0, 0,  6'b000000, 0};
        vecs[6]  = '{0, 0, 0, 1,  0,  0, 0, 0,  3,  3,   0, 0,  6'b011000, 0};
        vecs[7]  = '{0, 0, 0, 0,  0,  0, 0, 0,  0,  0,   0, 0,  6'b000100, 0};
        vecs[8]  = '{0, 0, 0, 0,  0,  0, 0, 0,  1,  0,   1, 0,  6'b000000, 0};
        vecs[9]  = '{0, 0, 0, 1,  1,  1, 1, 0,  0,  0,   1, 0,  6'b000000, 0};
        vecs[10] = '{1, 0, 0, 0,  1,  0, 0, 0,  0,  1,   1, 1,  6'b000000, 0};
        vecs[11] = '{0, 0, 0, 1,  0,  0, 0, 0,  0,  2,   1, 0,  6'b000000, 0};
        vecs[12] = '{0, 0, 0, 0,  0,  0, 0, 0,  0,  3,   1, 0,  6'b010000, 0};
        vecs[13] = '{0, 0, 0, 0,  0,  0, 0, 0,  0,  0,   1, 0,  6'b000101, 0};
        vecs[14] = '{0, 0, 0, 0,  0,  0, 0, 0,  0,  0,   0, 0,  6'b000010, 1};
        vecs[15] = '{1, 0, 1, 0,  0,  0, 0, 0,  0,  0,   0, 0,  6'b000010, 1};
        vecs[16] = '{0, 0, 0, 0,  0,  0, 0, 0,  0,  0,   0, 0,  6'b100000, 1};
        vecs[17] = '{0, 0, 0, 0,  0,  0, 0, 0,  1,  0,   0, 0,  6'b000000, 1};
        vecs[18] = '{0, 0, 0, 0,  0,  1, 1, 0,  0,  0,   0, 0,  6'b000000, 1};
        vecs[19] = '{0, 1, 0, 0,  1,  1, 0, 0,  0,  1,   0, 1,  6'b000000, 1};
        vecs[20] = '{0, 0, 0, 1,  0,  0, 0, 0,  2,  3,   0, 0,  6'b011000, 1};
        vecs[21] = '{0, 0, 0, 0,  0,  0, 0, 0,  0,  0,   0, 0,  6'b000100, 1};
        vecs[22] = '{0, 0, 0, 0,  0,  0, 0, 0,  1,  0,   1, 0,  6'b000000, 1};
        vecs[23] = '{0, 0, 0, 0,  1,  1, 1, 0,  3,  0,   1, 0,  6'b000000, 1};
        vecs[24] = '{0, 0, 0, 1,  1,  1, 1, 0,  0,  0,   1, 1,  6'b000000, 1};
        vecs[25] = '{0, 0, 0, 0,  0,  0, 0, 0,  0,  3,   1, 0,  6'b010000, 1};
        vecs[26] = '{0, 0, 0, 0,  0,  0, 0, 0,  0,  0,   1, 0,  6'b000101, 1};
        vecs[27] = '{0, 0, 0, 0,  0,  0, 0, 0,  0,  0,   0, 0,  6'b000010, 2};

        rst_s = 1'b1; rst_m = 1'b1; rst_d = 1'b1;
        start_s = 1'b0; start_m = 1'b0; start_d = 1'b0;
        leak_en = 1'b0; reset_mode = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_s = 1'b0; rst_m = 1'b0; rst_d = 1'b0;

        // Two full 2x2 ticks: leak/subtract mode, then no-leak/zero mode.
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            start_s    = vecs[i].st;
            leak_en    = vecs[i].le;
            reset_mode = vecs[i].rm;
            applyStimulus(vecs[i].ovf, vecs[i].spk, vecs[i].xb, vecs[i].ie, vecs[i].ls);
            #1;
            checkOutput($sformatf("v%0d_ctl", i), 32'({sop_s, sadd_s}), 32'({vecs[i].sop, vecs[i].sadd}));
            checkOutput($sformatf("v%0d_addr", i), 32'({naddr_s, aaddr_s}), 32'({vecs[i].na, vecs[i].aa}));
            checkOutput($sformatf("v%0d_strb", i), 32'({sbw_s, osbw_s, osbd_s, pmw_s, rdy_s, done_s}), 32'(vecs[i].strb));
            checkOutput($sformatf("v%0d_tick", i), 32'(tick_s), 32'(vecs[i].tick));
        end

        // Five back-to-back ticks with start held high; 2-bit tick counter wraps.
        @(negedge clk);
        rst_s = 1'b1; start_s = 1'b0;
        @(negedge clk);
        rst_s = 1'b0; start_s = 1'b1; leak_en = 1'b0;
        for (int t = 0; t < 5; t++) begin
            cyc = 0; sbw_cnt = 0; got = 0;
            for (int c = 0; c < 40 && !got; c++) begin
                if (c > 0) @(negedge clk);
                #1;
                if (sbw_s) sbw_cnt++;
                if (sbw_cnt > 0) cyc++;
                if (done_s) got = 1;
            end
            checkOutput($sformatf("wrap%0d_done", t), 32'(got), 32'd1);
            checkOutput($sformatf("wrap%0d_len", t), 32'(cyc), 32'd11);
            checkOutput($sformatf("wrap%0d_starts", t), 32'(sbw_cnt), 32'd1);
            @(negedge clk);
            #1;
            checkOutput($sformatf("wrap%0d_tick", t), 32'(tick_s), 32'((t + 1) % 4));
            checkOutput($sformatf("wrap%0d_ready", t), 32'(rdy_s), 32'd1);
        end
        @(negedge clk);
        start_s = 1'b0;

        // 4x3 instance without leak: 25-cycle tick, adder never in leak mode.
        @(negedge clk);
        leak_en = 1'b0; start_m = 1'b1;
        #1;
        checkOutput("m_ready", 32'(rdy_m), 32'd1);
        cyc = 0; leak_cnt = 0; got = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            start_m = 1'b0;
            randomStimulus();
            #1;
            cyc++;
            if (sadd_m == 2'd2) leak_cnt++;
            if (done_m) got = 1;
        end
        checkOutput("m_done", 32'(got), 32'd1);
        checkOutput("m_len", 32'(cyc), 32'd25);
        checkOutput("m_noleak", 32'(leak_cnt), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("m_tick", 32'(tick_m), 32'd1);

        // Default 16x16 tick with leak and random datapath flags.
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        leak_en = 1'b1; rm_lat = 1'($urandom); reset_mode = rm_lat; start_d = 1'b1;
        #1;
        checkOutput("d_ready", 32'(rdy_d), 32'd1);
        @(negedge clk);
        start_d = 1'b0;
        randomStimulus();
        #1;
        checkOutput("d_start", 32'({sbw_d, rdy_d, sop_d}), 32'({1'b1, 1'b0, 2'd0}));
        done_cnt = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            randomStimulus();
            #1;
            checkOutput($sformatf("d_load%0d", n), 32'({sop_d, naddr_d, pmw_d}), 32'({2'd1, 4'(n), 1'b0}));
            for (int a = 0; a < 16; a++) begin
                @(negedge clk);
                randomStimulus();
                #1;
                tovf     = (in_ex & potential_ovf) | (!in_ex & !potential_ovf);
                exp_sop  = (spike_on_axon && crossbar && !tovf) ? 2'd3 : 2'd0;
                exp_sadd = in_ex ? 2'd0 : 2'd1;
                checkOutput($sformatf("d_acc%0d_%0d", n, a), 32'({sop_d, sadd_d, naddr_d, aaddr_d}),
                            32'({exp_sop, exp_sadd, 4'(n), 4'(a)}));
            end
            @(negedge clk);
            randomStimulus();
            #1;
            exp_sop = !(potential_ovf ^ leak_sign) ? 2'd3 : 2'd0;
            checkOutput($sformatf("d_leak%0d", n), 32'({sop_d, sadd_d}), 32'({exp_sop, 2'd2}));
            @(negedge clk);
            randomStimulus();
            #1;
            exp_sop = !potential_ovf ? 2'd0 : (rm_lat ? 2'd2 : 2'd3);
            checkOutput($sformatf("d_thresh%0d", n), 32'({sop_d, sadd_d, osbw_d, osbd_d}),
                        32'({exp_sop, 2'd3, 1'b1, potential_ovf}));
            @(negedge clk);
            randomStimulus();
            #1;
            if (done_d) done_cnt++;
            checkOutput($sformatf("d_loop%0d", n), 32'({pmw_d, done_d, naddr_d, sop_d}),
                        32'({1'b1, (n == 15), 4'(n), 2'd0}));
        end
        checkOutput("d_donecount", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            randomStimulus();
            #1;
            checkOutput($sformatf("d_idle%0d", i), 32'({rdy_d, done_d, sbw_d, tick_d}), 32'({3'b100, 8'd1}));
        end

        // Reset in the middle of neuron 5's accumulation.
        @(negedge clk);
        leak_en = 1'b1; start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        repeat (105) begin
            @(negedge clk);
            randomStimulus();
        end
        #1;
        checkOutput("r_pos", 32'({naddr_d, aaddr_d}), 32'({4'd5, 4'd3}));
        rst_d = 1'b1; start_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0; start_d = 1'b0;
        #1;
        checkOutput("r_state", 32'({rdy_d, naddr_d, aaddr_d, tick_d}), 32'({1'b1, 4'd0, 4'd0, 8'd0}));
        checkOutput("r_wen", 32'({sbw_d, osbw_d, pmw_d, done_d}), 32'd0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst_d = 1'b1; start_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0; start_d = 1'b0;
        #1;
        checkOutput("r_overstart", 32'({rdy_d, sbw_d}), 32'({1'b1, 1'b0}));
        @(negedge clk);
        #1;
        checkOutput("r_stillwait", 32'({rdy_d, sbw_d}), 32'({1'b1, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
